// File: rtl/counter_pkg.sv
// Shared types and helpers for the multi-mode counter: mode encoding,
// Gray conversion and mode classification.
package counter_pkg;

   typedef enum logic [1:0] {
      BINARY  = 2'd0,
      GRAY    = 2'd1,
      JOHNSON = 2'd2,
      RING    = 2'd3
   } counter_mode_e;

   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Binary and Gray share the same underlying count register.
   function automatic logic is_bin_gray(input counter_mode_e mode);
      return (mode == BINARY) || (mode == GRAY);
   endfunction

endpackage

// File: rtl/clock_divider.sv
// Divides the input clock into a square wave at FREQUENCY and emits a
// one-cycle step strobe in the cycle that drives the square wave high.
module clock_divider #(
   parameter int CLK_HZ    = 50000000,
   parameter int FREQUENCY = 1000000
) (
   input  logic i_clk,
   input  logic i_reset,
   output logic o_sync_clock,
   output logic o_step
);

   localparam int HALF = CLK_HZ / (2 * FREQUENCY);
   localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [DW-1:0] LAST = DW'(HALF - 1);

   logic [DW-1:0] r_div;
   logic          r_sync;
   logic          w_last;

   assign w_last = (r_div == LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_div  <= '0;
         r_sync <= 1'b0;
      end else if (w_last) begin
         r_div  <= '0;
         r_sync <= ~r_sync;
      end else begin
         r_div  <= r_div + DW'(1);
      end
   end

   assign o_sync_clock = r_sync;
   assign o_step       = w_last & ~r_sync;

endmodule

// File: rtl/param_counter.sv
// Multi-mode counter (binary, Gray, Johnson, ring) advanced by a divided
// step strobe, with load, pause, direction and saturate/wrap control.
module param_counter
   import counter_pkg::*;
#(
   parameter int               WIDTH     = 5,
   parameter logic [WIDTH-1:0] INITIAL   = 5'b01001,
   parameter int               CLK_HZ    = 50000000,
   parameter int               FREQUENCY = 1000000
) (
   input  logic             i_clock_50mhz,
   input  logic             i_reset,
   input  logic             i_set,
   input  logic             i_pause,
   input  logic             i_count,
   input  logic [1:0]       i_type,
   input  logic             i_sat,
   output logic [WIDTH-1:0] o_value,
   output logic             o_sync_clock,
   output logic             o_wrap,
   output logic             o_at_limit
);

   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   counter_mode_e    r_mode;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_shift;
   logic             r_wrap;

   logic             w_step;
   counter_mode_e    w_type;
   logic [WIDTH-1:0] w_cnt_step;
   logic             w_cnt_wrap;
   logic [WIDTH-1:0] w_shift_step;
   logic             w_shift_wrap;

   function automatic logic [WIDTH-1:0] shift_seed(input counter_mode_e mode);
      return (mode == RING) ? WIDTH'(1) : '0;
   endfunction

   clock_divider #(
      .CLK_HZ   (CLK_HZ),
      .FREQUENCY(FREQUENCY)
   ) u_clock_divider (
      .i_clk       (i_clock_50mhz),
      .i_reset     (i_reset),
      .o_sync_clock(o_sync_clock),
      .o_step      (w_step)
   );

   assign w_type = counter_mode_e'(i_type);

   // At a limit: wrap with a pulse, or hold silently when saturating.
   always_comb begin
      w_cnt_step = r_cnt;
      w_cnt_wrap = 1'b0;
      if (i_count) begin
         if (r_cnt == ALL_ONES) begin
            if (!i_sat) begin
               w_cnt_step = '0;
               w_cnt_wrap = 1'b1;
            end
         end else begin
            w_cnt_step = r_cnt + WIDTH'(1);
         end
      end else begin
         if (r_cnt == '0) begin
            if (!i_sat) begin
               w_cnt_step = ALL_ONES;
               w_cnt_wrap = 1'b1;
            end
         end else begin
            w_cnt_step = r_cnt - WIDTH'(1);
         end
      end
   end

   always_comb begin
      w_shift_step = r_shift;
      case (r_mode)
         JOHNSON: w_shift_step = i_count ? {r_shift[WIDTH-2:0], ~r_shift[WIDTH-1]}
                                         : {~r_shift[0], r_shift[WIDTH-1:1]};
         RING:    w_shift_step = i_count ? {r_shift[WIDTH-2:0], r_shift[WIDTH-1]}
                                         : {r_shift[0], r_shift[WIDTH-1:1]};
         default: w_shift_step = r_shift;
      endcase
      w_shift_wrap = (w_shift_step == shift_seed(r_mode));
   end

   always_ff @(posedge i_clock_50mhz) begin
      if (i_reset) begin
         r_mode  <= BINARY;
         r_cnt   <= INITIAL;
         r_shift <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         if (i_set) begin
            if (is_bin_gray(r_mode)) r_cnt   <= INITIAL;
            else                     r_shift <= shift_seed(r_mode);
         end else if (w_type != r_mode) begin
            r_mode <= w_type;
            // Binary<->Gray is only a re-encoding of the same count.
            if (!(is_bin_gray(r_mode) && is_bin_gray(w_type))) begin
               if (is_bin_gray(w_type)) r_cnt   <= INITIAL;
               else                     r_shift <= shift_seed(w_type);
            end
         end else if (i_pause) begin
            r_wrap <= 1'b0;
         end else if (w_step) begin
            if (is_bin_gray(r_mode)) begin
               r_cnt  <= w_cnt_step;
               r_wrap <= w_cnt_wrap;
            end else begin
               r_shift <= w_shift_step;
               r_wrap  <= w_shift_wrap;
            end
         end
      end
   end

   always_comb begin
      case (r_mode)
         BINARY:  o_value = r_cnt;
         GRAY:    o_value = WIDTH'(bin2gray(32'(r_cnt)));
         default: o_value = r_shift;
      endcase
   end

   assign o_wrap     = r_wrap;
   assign o_at_limit = is_bin_gray(r_mode) &
                       (i_count ? (r_cnt == ALL_ONES) : (r_cnt == '0));

endmodule

// File: tb/tb_param_counter.sv
// Directed bench for param_counter (WIDTH=5, INITIAL=9, HALF=25): stimulus
// pushes expected {value, wrap, at_limit} per step; a monitor pops and compares.
module tb_param_counter;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_set;
  logic       i_pause;
  logic       i_count;
  logic [1:0] i_type;
  logic       i_sat;
  logic [4:0] o_value;
  logic       o_sync_clock;
  logic       o_wrap;
  logic       o_at_limit;

  int errors = 0;
  int checks = 0;
  logic [6:0] exp_q[$];
  logic [6:0] m_exp;
  logic       m_prev = 1'b0;
  int         cyc;

  logic [4:0] john_up [10];
  logic [4:0] john_dn [10];
  logic [4:0] ring_dn [5];
  logic [4:0] ring_up [5];

  always #10 clk = ~clk;

  param_counter #(
    .WIDTH    (5),
    .INITIAL  (5'b01001),
    .CLK_HZ   (50000000),
    .FREQUENCY(1000000)
  ) dut (
    .i_clock_50mhz(clk),
    .i_reset      (i_reset),
    .i_set        (i_set),
    .i_pause      (i_pause),
    .i_count      (i_count),
    .i_type       (i_type),
    .i_sat        (i_sat),
    .o_value      (o_value),
    .o_sync_clock (o_sync_clock),
    .o_wrap       (o_wrap),
    .o_at_limit   (o_at_limit)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: on every rising edge of o_sync_clock compare against the queue;
  // in all other cycles o_wrap must be low.
  always @(negedge clk) begin
    if (!i_reset && o_sync_clock && !m_prev) begin
      if (exp_q.size() > 0) begin
        m_exp = exp_q.pop_front();
        check("step_value", 32'(o_value), 32'(m_exp[6:2]));
        check("step_wrap", 32'(o_wrap), 32'(m_exp[1]));
        check("step_limit", 32'(o_at_limit), 32'(m_exp[0]));
      end
    end else if (!i_reset) begin
      check("wrap_idle", 32'(o_wrap), 32'd0);
    end
    m_prev = o_sync_clock;
  end

  // Waits for the next rising edge of o_sync_clock, returning the number of
  // clock edges taken; returns just after the monitor's sample point.
  task automatic wait_step(output int cycles);
    logic p;
    bit   found;
    p = o_sync_clock;
    cycles = 0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (o_sync_clock && !p) begin
        found = 1'b1;
        break;
      end
      p = o_sync_clock;
    end
    if (!found) begin
      errors++;
      checks++;
      $display("FAIL step_timeout: got no step in %0d cycles expected one", cycles);
    end
    @(negedge clk);
    #2;
  endtask

  task automatic step(input logic [4:0] v, input logic w, input logic l);
    int c;
    exp_q.push_back({v, w, l});
    wait_step(c);
  endtask

  task automatic edge_then_check(input string name, input logic [4:0] req);
    @(posedge clk);
    #1;
    check(name, 32'(o_value), 32'(req));
  endtask

  initial begin
    john_up = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111,
                5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};
    john_dn = '{5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111,
                5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000};
    ring_dn = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
    ring_up = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};

    i_reset = 1'b1;
    i_set   = 1'b0;
    i_pause = 1'b0;
    i_count = 1'b1;
    i_type  = 2'd0;
    i_sat   = 1'b0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_value", 32'(o_value), 32'd9);
    check("reset_sync", 32'(o_sync_clock), 32'd0);
    check("reset_wrap", 32'(o_wrap), 32'd0);
    check("reset_limit", 32'(o_at_limit), 32'd0);
    i_reset = 1'b0;

    exp_q.push_back({5'd10, 1'b0, 1'b0});
    wait_step(cyc);
    check("first_step_latency", cyc, 32'd25);

    // Gray re-encodes the live count 10 -> 01111, then 11 -> 01110.
    i_type = 2'd1;
    edge_then_check("gray_switch", 5'b01111);
    step(5'b01110, 1'b0, 1'b0);
    i_type = 2'd0;
    edge_then_check("back_to_binary", 5'd11);

    step(5'd12, 1'b0, 1'b0);
    exp_q.push_back({5'd13, 1'b0, 1'b0});
    wait_step(cyc);
    check("sync_period", cyc, 32'd50);
    for (int v = 14; v <= 20; v++) step(5'(v), 1'b0, 1'b0);

    // Set and pause together: set wins, then the count stays frozen.
    i_set   = 1'b1;
    i_pause = 1'b1;
    edge_then_check("set_load", 5'd9);
    i_set = 1'b0;
    for (int k = 0; k < 3; k++) step(5'd9, 1'b0, 1'b0);
    i_pause = 1'b0;
    for (int v = 10; v <= 30; v++) step(5'(v), 1'b0, 1'b0);

    i_sat = 1'b1;
    step(5'd31, 1'b0, 1'b1);
    step(5'd31, 1'b0, 1'b1);
    i_sat = 1'b0;
    step(5'd0, 1'b1, 1'b0);
    step(5'd1, 1'b0, 1'b0);

    i_count = 1'b0;
    step(5'd0, 1'b0, 1'b1);
    step(5'd31, 1'b1, 1'b0);
    i_count = 1'b1;
    #1;
    check("limit_follows_dir", 32'(o_at_limit), 32'd1);

    i_type = 2'd2;
    edge_then_check("johnson_seed", 5'b00000);
    for (int i = 0; i < 10; i++) step(john_up[i], (i == 9), 1'b0);
    i_count = 1'b0;
    for (int i = 0; i < 10; i++) step(john_dn[i], (i == 9), 1'b0);

    i_type = 2'd3;
    edge_then_check("ring_seed", 5'b00001);
    for (int i = 0; i < 5; i++) step(ring_dn[i], (i == 4), 1'b0);
    i_count = 1'b1;
    for (int i = 0; i < 5; i++) step(ring_up[i], (i == 4), 1'b0);

    i_type = 2'd0;
    edge_then_check("ring_to_binary", 5'd9);
    step(5'd10, 1'b0, 1'b0);

    // Reset sampled while the divider holds 12 discards the partial period.
    repeat (12) @(posedge clk);
    #1;
    i_reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("midreset_value", 32'(o_value), 32'd9);
    check("midreset_sync", 32'(o_sync_clock), 32'd0);
    i_reset = 1'b0;
    exp_q.push_back({5'd10, 1'b0, 1'b0});
    wait_step(cyc);
    check("midreset_latency", cyc, 32'd25);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 5: counter width in bits, minimum 2.
REQ-002 SHALL have parameter INITIAL, default 5'b01001: load value for binary/gray modes.
REQ-003 SHALL have parameter CLK_HZ, default 50000000: input clock frequency.
REQ-004 SHALL have parameter FREQUENCY, default 1000000: step rate; HALF = CLK_HZ/(2*FREQUENCY), HALF >= 1.
REQ-005 SHALL have port i_clock_50mhz  in  1  sole clock, rising edge.
REQ-006 SHALL have port i_reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port i_set  in  1  load the seed of the current mode.
REQ-008 SHALL have port i_pause  in  1  freeze the count; the divider keeps running.
REQ-009 SHALL have port i_count  in  1  direction, 1 = up, 0 = down.
REQ-010 SHALL have port i_type  in  2  mode: 0 binary, 1 gray, 2 johnson, 3 ring.
REQ-011 SHALL have port i_sat  in  1  1 = saturate at limits (binary/gray only), 0 = wrap.
REQ-012 SHALL have port o_value  out  WIDTH  encoded count.
REQ-013 SHALL have port o_sync_clock  out  1  square wave at FREQUENCY.
REQ-014 SHALL have port o_wrap  out  1  one-cycle pulse on wrap-around.
REQ-015 SHALL have port o_at_limit  out  1  level, binary count at the limit in the current direction.

Function
REQ-016 Divider SHALL count 0..HALF-1 and toggle o_sync_clock when the count is HALF-1; the count then returns to 0.
REQ-017 step SHALL be asserted in the cycle where the divider toggles o_sync_clock from 0 to 1; step period is 2*HALF cycles.
REQ-018 o_value SHALL update on the same edge that drives o_sync_clock high (latency 1 from step).
REQ-019 Per-cycle priority SHALL be: reset > set > mode change > pause > step.
REQ-020 Binary/gray state SHALL be one WIDTH-bit register cnt; o_value SHALL be cnt in binary mode and cnt^(cnt>>1) in gray mode.
REQ-021 Johnson state SHALL shift left, inserting ~MSB (up) or shift right inserting ~LSB (down): 2*WIDTH states, seed 0.
REQ-022 Ring state SHALL rotate left (up) or right (down), seed 1 (one-hot LSB).
REQ-023 Seed SHALL be INITIAL for binary/gray, 0 for johnson, 1 for ring.
REQ-024 Mode change: registered mode SHALL update to i_type, and state SHALL load the new mode's seed, except that a binary<->gray change keeps cnt.
REQ-025 Binary/gray wrap mode: up at 2^WIDTH-1 SHALL go to 0, down at 0 SHALL go to 2^WIDTH-1, each with o_wrap high for 1 cycle.
REQ-026 Binary/gray saturate mode: a step at the limit SHALL hold the value, with no o_wrap.
REQ-027 Johnson/ring SHALL always wrap; o_wrap SHALL pulse when a step lands on the seed.
REQ-028 o_at_limit SHALL be high when binary/gray and (up and cnt = all-ones, or down and cnt = 0); it SHALL be 0 in johnson/ring.
REQ-029 Direction or i_sat change SHALL take effect at the next step, with no state reload.
REQ-030 Set, mode change, and pause SHALL NOT affect the divider or o_sync_clock.

Reset
REQ-031 On i_reset, the following SHALL be loaded: divider 0, o_sync_clock 0, mode binary, cnt INITIAL, o_wrap 0.
REQ-032 Outputs during and after reset SHALL be: o_value = INITIAL, o_at_limit = (INITIAL == all-ones), per i_count.
REQ-033 Reset asserted mid-period SHALL discard the partial divider count; the first step SHALL come HALF cycles after release.

Structure
REQ-034 Package counter_pkg SHALL hold enum counter_mode_e (BINARY, GRAY, JOHNSON, RING) and function bin2gray.
REQ-035 Sub-module clock_divider (parameters CLK_HZ, FREQUENCY; outputs o_sync_clock and step) SHALL be instantiated once.
REQ-036 Counter state and encoding SHALL be in param_counter; all regs SHALL be clocked by i_clock_50mhz.

Verification (WIDTH=5, INITIAL=9, HALF=25)
REQ-037 Reset 5 cycles, then binary up, no pause -> o_value 9; 10 at release+25 cycles; 11 at +75; o_sync_clock period 50.
REQ-038 Binary up from 30, i_sat=1 -> 31, then 31 held, o_at_limit=1, o_wrap=0; with i_sat=0 -> 31, 0, and o_wrap high exactly 1 cycle.
REQ-039 cnt=10, switch to gray -> o_value 01111 next cycle; next step -> 11 encoded 01110.
REQ-040 Johnson up from reset -> 00000, 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000, 00000 with o_wrap pulse; down reverses.
REQ-041 Set and pause together at cnt=20 -> 9; pause held for 3 steps -> 9 stays, o_sync_clock keeps toggling.
REQ-042 Reset asserted at divider count 12 -> o_value 9, o_sync_clock 0; next step 25 cycles after release.
